// File: rtl/intan_fifo_drain_if.sv
// Bundles the per-channel Intan byte FIFO read ports (fifoi) and the
// framed output data FIFO write port (fifod) between the drain and the
// FIFOs around it.
//   fifoi_rxen  : per-FIFO read enable, one-hot or zero (drain -> FIFOs)
//   fifoi_rxd   : FIFO i byte on [8i+7:8i], valid the cycle after rxen
//   fifoi_empty : per-FIFO empty flag
//   fifod_full  : output FIFO almost-full (at least 2 free slots when high)
//   fifod_txen  : output FIFO write strobe (drain -> fifod)
//   fifod_txd   : output FIFO write data
// master = the drain, slave = the FIFO side.
interface intan_fifo_drain_if #(
  parameter int NUM_DEV = 4
) ();
  logic [2*NUM_DEV-1:0]  fifoi_rxen;
  logic [16*NUM_DEV-1:0] fifoi_rxd;
  logic [2*NUM_DEV-1:0]  fifoi_empty;
  logic                  fifod_full;
  logic                  fifod_txen;
  logic [7:0]            fifod_txd;

  modport master (
    output fifoi_rxen,
    input  fifoi_rxd,
    input  fifoi_empty,
    input  fifod_full,
    output fifod_txen,
    output fifod_txd
  );

  modport slave (
    input  fifoi_rxen,
    output fifoi_rxd,
    output fifoi_empty,
    output fifod_full,
    input  fifod_txen,
    input  fifod_txd
  );
endinterface

// File: rtl/intan_fifo_drain.sv
// Drains the 2*NUM_DEV per-channel Intan byte FIFOs (visited highest index
// first) into one framed byte stream on fifod:
//   0x55 0xAA smpr kind frame_cnt <payload of each present FIFO> checksum
// A FIFO that stays empty for TMO cycles while bytes are still owed is
// padded with 0x00 so the frame length never depends on the capture side.
// Ports:
//   clk, rst  : system clock, synchronous active-high reset
//   fs_fifo   : frame start request (level)
//   fd_fifo   : frame done, held until fs_fifo drops
//   err       : sticky timeout flag, cleared when the next frame starts
//   dev_kind  : 2 bits per device (00 absent, 01/10/11 = 32/64/128 B/FIFO)
//   dev_smpr  : sample-rate code copied into the header
//   bus       : fifoi read ports and fifod write port (master side)
module intan_fifo_drain #(
  parameter int NUM_DEV = 4,
  parameter int TMO     = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fs_fifo,
  output logic                 fd_fifo,
  output logic                 err,
  input  logic [2*NUM_DEV-1:0] dev_kind,
  input  logic [7:0]           dev_smpr,
  intan_fifo_drain_if.master   bus
);
  localparam int NF = 2 * NUM_DEV;
  localparam int IW = $clog2(NF);
  localparam int TW = $clog2(TMO + 1);

  typedef enum logic [2:0] {IDLE, HEAD, SEL, READ, TAIL, DONE} state_t;

  state_t          state;
  logic [NF-1:0]   kind_q;
  logic [7:0]      smpr_q;
  logic [7:0]      frame_cnt;
  logic [2:0]      hidx;
  logic [IW:0]     nxt;
  logic [IW-1:0]   cur;
  logic [7:0]      rem;
  logic [TW-1:0]   tmo_cnt;
  logic            flush;
  logic [7:0]      csum;
  logic            txen_q;
  logic            tx_pay;
  logic [7:0]      tx_byte;

  logic [7:0]      rxd_arr [NF];
  logic [7:0]      rxd_sel;
  logic            pay_wr;
  logic [7:0]      csum_next;
  logic            issue;
  logic [NF-1:0]   rxen;
  logic            found;
  logic [IW-1:0]   sel_idx;
  logic [1:0]      sel_kind;
  logic [7:0]      hdr_byte;

  always_comb begin
    for (int i = 0; i < NF; i++) begin
      rxd_arr[i] = bus.fifoi_rxd[8*i +: 8];
    end
  end

  // A payload byte read from FIFO cur appears on fifoi_rxd the cycle after
  // rxen, so the write data is muxed straight from the FIFO in that cycle;
  // the checksum looks ahead through csum_next so TAIL never misses it.
  assign rxd_sel   = rxd_arr[cur];
  assign pay_wr    = txen_q & tx_pay;
  assign csum_next = csum + (pay_wr ? rxd_sel : 8'h00);

  // Read enable is qualified with this cycle's empty/full so a FIFO is never
  // read while empty and back-to-back reads run at one byte per cycle.
  assign issue = (state == READ) && !flush && (rem != 8'd0) &&
                 !bus.fifoi_empty[cur] && !bus.fifod_full;

  always_comb begin
    rxen = '0;
    if (issue) rxen[cur] = 1'b1;
  end

  // Highest-numbered FIFO below nxt whose device is present; FIFO j
  // belongs to the kind field that covers bit pair j/2.
  always_comb begin
    found    = 1'b0;
    sel_idx  = '0;
    sel_kind = 2'b00;
    for (int j = NF - 1; j >= 0; j--) begin
      if (!found && (j < int'(nxt)) && (kind_q[2*(j/2) +: 2] != 2'b00)) begin
        found    = 1'b1;
        sel_idx  = IW'(j);
        sel_kind = kind_q[2*(j/2) +: 2];
      end
    end
  end

  always_comb begin
    case (hidx)
      3'd0:    hdr_byte = 8'h55;
      3'd1:    hdr_byte = 8'hAA;
      3'd2:    hdr_byte = smpr_q;
      3'd3:    hdr_byte = 8'(kind_q);
      default: hdr_byte = frame_cnt;
    endcase
  end

  assign bus.fifoi_rxen = rxen;
  assign bus.fifod_txen = txen_q;
  assign bus.fifod_txd  = tx_pay ? rxd_sel : tx_byte;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      kind_q    <= '0;
      smpr_q    <= 8'h00;
      frame_cnt <= 8'h00;
      hidx      <= 3'd0;
      nxt       <= '0;
      cur       <= '0;
      rem       <= 8'h00;
      tmo_cnt   <= '0;
      flush     <= 1'b0;
      csum      <= 8'h00;
      txen_q    <= 1'b0;
      tx_pay    <= 1'b0;
      tx_byte   <= 8'h00;
      fd_fifo   <= 1'b0;
      err       <= 1'b0;
    end else begin
      txen_q <= 1'b0;
      tx_pay <= 1'b0;
      if (pay_wr) csum <= csum_next;
      case (state)
        IDLE: begin
          if (fs_fifo && !fd_fifo) begin
            err    <= 1'b0;
            kind_q <= dev_kind;
            smpr_q <= dev_smpr;
            csum   <= 8'h00;
            nxt    <= (IW+1)'(NF);
            state  <= HEAD;
            // The constant sync byte goes out on the start edge itself.
            if (!bus.fifod_full) begin
              txen_q  <= 1'b1;
              tx_byte <= 8'h55;
              hidx    <= 3'd1;
            end else begin
              hidx    <= 3'd0;
            end
          end
        end
        HEAD: begin
          if (!bus.fifod_full) begin
            txen_q  <= 1'b1;
            tx_byte <= hdr_byte;
            if (hidx == 3'd4) state <= SEL;
            else              hidx  <= hidx + 3'd1;
          end
        end
        SEL: begin
          if (found) begin
            cur     <= sel_idx;
            nxt     <= (IW+1)'(sel_idx);
            rem     <= 8'd16 << sel_kind;
            tmo_cnt <= '0;
            flush   <= 1'b0;
            state   <= READ;
          end else begin
            state   <= TAIL;
          end
        end
        READ: begin
          if (flush) begin
            if (!bus.fifod_full) begin
              txen_q  <= 1'b1;
              tx_byte <= 8'h00;
              rem     <= rem - 8'd1;
              if (rem == 8'd1) state <= SEL;
            end
          end else if (issue) begin
            txen_q  <= 1'b1;
            tx_pay  <= 1'b1;
            rem     <= rem - 8'd1;
            tmo_cnt <= '0;
            if (rem == 8'd1) state <= SEL;
          end else if (bus.fifoi_empty[cur]) begin
            if (tmo_cnt == TW'(TMO - 1)) begin
              flush <= 1'b1;
              err   <= 1'b1;
            end else begin
              tmo_cnt <= tmo_cnt + TW'(1);
            end
          end
        end
        TAIL: begin
          if (!bus.fifod_full) begin
            txen_q    <= 1'b1;
            tx_byte   <= csum_next;
            frame_cnt <= frame_cnt + 8'd1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (fd_fifo && !fs_fifo) begin
            fd_fifo <= 1'b0;
            state   <= IDLE;
          end else begin
            fd_fifo <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/intan_fifo_drain.md
# intan_fifo_drain

Drains the eight per-channel Intan byte FIFOs (two per Intan device, four devices) and serialises their contents into one framed byte stream on the data FIFO (fifod). It sits between the four intan capture blocks, which write fifoi, and the USB/uplink path, which reads fifod. A frame is started by the fs_fifo/fd_fifo handshake from the top-level controller.

## Interface
- NUM_DEV, 4: Intan devices; FIFO count is 2*NUM_DEV.
- TMO, 1024: cycles a FIFO may stay empty while bytes are still owed before timeout.
- clk  in  1  system clock (sysc domain); all fifoi read and fifod write ports are on this clock.
- rst  in  1  synchronous, active-high reset.
- fs_fifo  in  1  frame start request, level.
- fd_fifo  out  1  frame done, held high until fs_fifo drops.
- err  out  1  sticky timeout flag, cleared on next accepted fs_fifo.
- dev_kind  in  8  2 bits per device: 00 absent, 01 → 32 bytes/FIFO, 10 → 64, 11 → 128.
- dev_smpr  in  8  sample-rate code, copied into header.
- fifoi_rxen  out  8  read enable per FIFO, one-hot or zero.
- fifoi_rxd  in  64  FIFO i data on [8i+7:8i], valid 1 cycle after rxen (standard, non-FWFT).
- fifoi_empty  in  8  per-FIFO empty.
- fifod_full  in  1  fifod almost-full, with at least 2 free slots when asserted.
- fifod_txen  out  1  fifod write strobe.
- fifod_txd  out  8  fifod write data.

## Operation
- Device k (0..3) owns FIFOs 7-2k and 6-2k and kind field dev_kind[7-2k:6-2k]; FIFOs are visited 7 down to 0.
- The frame format is, in order: 0x55, 0xAA, dev_smpr, dev_kind, frame_cnt, the payload of each non-absent FIFO in visit order, then a checksum.
- dev_kind and dev_smpr are latched when the frame starts.
- frame_cnt is 8 bits, resets to 0, increments on entering DONE, and wraps 255→0.
- The checksum is the 8-bit sum of payload bytes mod 256; header bytes are excluded. With no payload the checksum is 0x00.
- States: IDLE, HEAD, SEL, READ, TAIL, DONE.
  - IDLE → HEAD when fs_fifo=1 and fd_fifo=0. On this transition err clears, the latches load, and the byte index resets.
  - HEAD emits the 5 header bytes, one per cycle while fifod_full=0, then goes to SEL.
  - SEL picks the next FIFO whose device kind ≠ 00. It loads the remaining count and the timeout counter, then goes to READ. If no FIFO is left it goes to TAIL.
  - READ issues fifoi_rxen[i] in a cycle only when remaining>0, fifoi_empty[i]=0 and fifod_full=0; each issue decrements remaining. When remaining reaches 0 and the last byte has been written, go to SEL.
  - TAIL emits the checksum when fifod_full=0, then goes to DONE.
  - DONE holds fd_fifo=1 until fs_fifo=0, then goes to IDLE.
- Timeout: in READ, the counter increments on each cycle that bytes are owed and fifoi_empty[i]=1. The counter clears on any issue.
  - At TMO, err is set and every remaining byte of that FIFO is emitted as 0x00, without rxen, one per non-full cycle. Those bytes are added to the checksum.
  - Frame length is therefore always deterministic.
- fifod_full does not stall the data return of an rxen already issued.
- rst at any point: all outputs go to 0 and state to IDLE; frame_cnt is 0 and err is 0. Partial frame state is discarded; fifoi bytes already read are lost.

## Timing
- All outputs reset to 0 and are registered.
- fs_fifo is sampled in IDLE at edge t. The first header byte has fifod_txen=1 in cycle t+1.
- Payload latency: fifoi_rxen[i] high in cycle t gives fifod_txen=1 with that byte in cycle t+1.
- Throughput is 1 byte/cycle with no gap at FIFO boundaries beyond one SEL cycle.
- Frame length is 6 + 2·Σ bytes_per_FIFO(k).
- fd_fifo rises 1 cycle after the checksum write and falls 1 cycle after fs_fifo=0 is sampled.
- fifoi_rxen is never asserted for a FIFO with empty=1 in the same cycle.

## Test plan
- dev_kind=0x40 (device 0, 32B), FIFO7 holds 0x00..0x1F and FIFO6 holds 0x20..0x3F, dev_smpr=0x03.
  - Required: 70 bytes: 55 AA 03 40 00, 0x00..0x3F, then checksum 0xE0.
  - fd_fifo rises and err=0.
- dev_kind=0x00 → 6 bytes: 55 AA smpr 00 cnt 00. fifoi_rxen never asserted.
- dev_kind=0xFF with all FIFOs prefilled to 128B, and fifod_full toggling pseudo-randomly.
  - Required: 1030 bytes identical to the no-backpressure run.
  - No write occurs while full has been high for 2+ cycles.
- dev_kind=0x10, with FIFO5 holding 10 bytes of the 32 owed.
  - Required: after TMO empty cycles, err=1 and 22×0x00 are emitted.
  - The frame is still 70 bytes, and the checksum matches the emitted bytes.
- Assert rst during READ at byte 20.
  - Required: all outputs 0 next cycle.
  - A following fs_fifo produces a clean frame with frame_cnt=0.
- Run 257 back-to-back frames → frame_cnt byte sequence 0x00..0xFF, 0x00.
